// File: rtl/encoder_input_controller.sv
// Rotary encoder front end: synchronise and debounce the pins, decode full quadrature
// detents, and apply steps to a saturating value/step-size pair selected by a 3-mode edit FSM.
module encoder_input_controller #(
    parameter int CLOCK_DIVIDER    = 100000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk100Mhz,
    input  logic       reset,
    input  logic       enc_phase_a,
    input  logic       enc_phase_b,
    input  logic       enc_switch,
    output logic       step_pulse,
    output logic       step_dir,
    output logic [1:0] mode,
    output logic [7:0] value,
    output logic [7:0] led
);

    localparam int DIV_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int DB_W  = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [2:0] {
        Q_IDLE, Q_R1, Q_R2, Q_R3, Q_L1, Q_L2, Q_L3, Q_RESYNC
    } quad_t;

    typedef enum logic [1:0] {
        EDIT_VALUE = 2'd0,
        EDIT_STEP  = 2'd1,
        LOCKED     = 2'd2
    } mode_t;

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;
    logic [2:0]       pins;
    logic [2:0]       deb;
    logic [1:0]       ab;

    quad_t            quad_reg;
    mode_t            mode_reg;
    logic             step_pulse_reg;
    logic             step_dir_reg;
    logic             sw_prev_reg;
    logic [7:0]       value_reg;
    logic [7:0]       step_size_reg;
    logic [7:0]       led_reg;
    logic             press;
    logic [8:0]       sum_9;
    logic [8:0]       diff_9;

    assign tick = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk100Mhz) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Bit order: 0 = phase A, 1 = phase B, 2 = push switch.
    assign pins = {enc_switch, enc_phase_b, enc_phase_a};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_input
            logic            s1_reg;
            logic            s2_reg;
            logic            deb_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk100Mhz) begin
                if (reset) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    deb_reg <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg <= pins[gi];
                    s2_reg <= s1_reg;
                    if (tick) begin
                        if (s2_reg == deb_reg) begin
                            cnt_reg <= '0;
                        end else if (cnt_reg == DB_LAST) begin
                            deb_reg <= s2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign deb[gi] = deb_reg;
        end
    endgenerate

    assign ab = {deb[0], deb[1]};

    // A detent counts only when the full Gray cycle completes back at 00.
    always_ff @(posedge clk100Mhz) begin
        if (reset) begin
            quad_reg       <= Q_IDLE;
            step_pulse_reg <= 1'b0;
            step_dir_reg   <= 1'b0;
        end else begin
            step_pulse_reg <= 1'b0;
            case (quad_reg)
                Q_IDLE: begin
                    if (ab == 2'b10)      quad_reg <= Q_R1;
                    else if (ab == 2'b01) quad_reg <= Q_L1;
                    else if (ab == 2'b11) quad_reg <= Q_RESYNC;
                end
                Q_R1: begin
                    if (ab == 2'b11)      quad_reg <= Q_R2;
                    else if (ab == 2'b00) quad_reg <= Q_IDLE;
                    else if (ab == 2'b01) quad_reg <= Q_RESYNC;
                end
                Q_R2: begin
                    if (ab == 2'b01)      quad_reg <= Q_R3;
                    else if (ab == 2'b10) quad_reg <= Q_R1;
                    else if (ab == 2'b00) quad_reg <= Q_RESYNC;
                end
                Q_R3: begin
                    if (ab == 2'b00) begin
                        quad_reg       <= Q_IDLE;
                        step_pulse_reg <= 1'b1;
                        step_dir_reg   <= 1'b0;
                    end else if (ab == 2'b11) begin
                        quad_reg <= Q_R2;
                    end else if (ab == 2'b10) begin
                        quad_reg <= Q_RESYNC;
                    end
                end
                Q_L1: begin
                    if (ab == 2'b11)      quad_reg <= Q_L2;
                    else if (ab == 2'b00) quad_reg <= Q_IDLE;
                    else if (ab == 2'b10) quad_reg <= Q_RESYNC;
                end
                Q_L2: begin
                    if (ab == 2'b10)      quad_reg <= Q_L3;
                    else if (ab == 2'b01) quad_reg <= Q_L1;
                    else if (ab == 2'b00) quad_reg <= Q_RESYNC;
                end
                Q_L3: begin
                    if (ab == 2'b00) begin
                        quad_reg       <= Q_IDLE;
                        step_pulse_reg <= 1'b1;
                        step_dir_reg   <= 1'b1;
                    end else if (ab == 2'b11) begin
                        quad_reg <= Q_L2;
                    end else if (ab == 2'b01) begin
                        quad_reg <= Q_RESYNC;
                    end
                end
                default: begin
                    if (ab == 2'b00) quad_reg <= Q_IDLE;
                end
            endcase
        end
    end

    assign press  = deb[2] & ~sw_prev_reg;
    assign sum_9  = {1'b0, value_reg} + {1'b0, step_size_reg};
    assign diff_9 = {1'b0, value_reg} - {1'b0, step_size_reg};

    // A step uses mode_reg as it stood at step_pulse, even if a press advances it this edge.
    always_ff @(posedge clk100Mhz) begin
        if (reset) begin
            mode_reg      <= EDIT_VALUE;
            sw_prev_reg   <= 1'b0;
            value_reg     <= 8'h00;
            step_size_reg <= 8'h01;
            led_reg       <= 8'h00;
        end else begin
            sw_prev_reg <= deb[2];
            if (press) begin
                case (mode_reg)
                    EDIT_VALUE: mode_reg <= EDIT_STEP;
                    EDIT_STEP:  mode_reg <= LOCKED;
                    default:    mode_reg <= EDIT_VALUE;
                endcase
            end
            if (step_pulse_reg) begin
                case (mode_reg)
                    EDIT_VALUE: begin
                        if (!step_dir_reg) value_reg <= sum_9[8] ? 8'hFF : sum_9[7:0];
                        else               value_reg <= diff_9[8] ? 8'h00 : diff_9[7:0];
                    end
                    EDIT_STEP: begin
                        if (!step_dir_reg) begin
                            if (!step_size_reg[7]) step_size_reg <= step_size_reg << 1;
                        end else begin
                            if (!step_size_reg[0]) step_size_reg <= step_size_reg >> 1;
                        end
                    end
                    default: ;
                endcase
            end
            led_reg <= (mode_reg == EDIT_STEP) ? step_size_reg : value_reg;
        end
    end

    assign step_pulse = step_pulse_reg;
    assign step_dir   = step_dir_reg;
    assign mode       = mode_reg;
    assign value      = value_reg;
    assign led        = led_reg;

endmodule

// File: tb/tb_encoder_input_controller.sv
// Table-driven bench for encoder_input_controller: each row drives an encoder gesture and
// checks mode/value/led; every step_pulse is matched against a scoreboard of expected directions.
module tb_encoder_input_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_phase_a;
    logic       enc_phase_b;
    logic       enc_switch;
    logic       step_pulse;
    logic       step_dir;
    logic [1:0] mode;
    logic [7:0] value;
    logic [7:0] led;

    encoder_input_controller #(
        .CLOCK_DIVIDER   (1),
        .DEBOUNCE_SAMPLES(4)
    ) dut (
        .clk100Mhz  (clk),
        .reset      (reset),
        .enc_phase_a(enc_phase_a),
        .enc_phase_b(enc_phase_b),
        .enc_switch (enc_switch),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .mode       (mode),
        .value      (value),
        .led        (led)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {
        OP_RESET, OP_LEFT, OP_RIGHT, OP_PRESS, OP_GLITCH, OP_PARTIAL, OP_INVALID, OP_RESET11
    } op_t;

    typedef struct {
        op_t        op;
        int         count;
        logic [1:0] exp_mode;
        logic [7:0] exp_value;
        logic [7:0] exp_led;
    } vec_t;

    localparam int NVEC = 28;
    localparam int HOLD = 8;

    vec_t vecs[NVEC];
    bit   exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge and match any step_pulse against the scoreboard.
    task automatic clk_step();
        bit e;
        @(negedge clk);
        if (step_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL step_pulse: got unexpected pulse dir=%0d, required no pulse", step_dir);
            end else begin
                e = exp_q.pop_front();
                if (step_dir !== e) begin
                    errors++;
                    $display("FAIL step_dir: got %0d, required %0d", step_dir, e);
                end
            end
        end
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    task automatic set_phase(input bit a, input bit b, input int n);
        enc_phase_a = a;
        enc_phase_b = b;
        wait_clks(n);
    endtask

    task automatic detent(input bit left);
        if (!left) begin
            set_phase(1'b1, 1'b0, HOLD);
            set_phase(1'b1, 1'b1, HOLD);
            set_phase(1'b0, 1'b1, HOLD);
        end else begin
            set_phase(1'b0, 1'b1, HOLD);
            set_phase(1'b1, 1'b1, HOLD);
            set_phase(1'b1, 1'b0, HOLD);
        end
        exp_q.push_back(left);
        set_phase(1'b0, 1'b0, HOLD);
    endtask

    task automatic press_switch();
        enc_switch = 1'b1;
        wait_clks(10);
        enc_switch = 1'b0;
        wait_clks(10);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".step_pulse"}, {7'd0, step_pulse}, 8'h00);
        chk({tag, ".step_dir"}, {7'd0, step_dir}, 8'h00);
        chk({tag, ".mode"}, {6'd0, mode}, 8'h00);
        chk({tag, ".value"}, value, 8'h00);
        chk({tag, ".led"}, led, 8'h00);
    endtask

    initial begin
        vecs[0]  = '{OP_RESET,   1,  2'd0, 8'd0,   8'h00};
        vecs[1]  = '{OP_LEFT,    3,  2'd0, 8'd0,   8'h00};
        vecs[2]  = '{OP_RIGHT,   5,  2'd0, 8'd5,   8'h05};
        vecs[3]  = '{OP_PRESS,   1,  2'd1, 8'd5,   8'h01};
        vecs[4]  = '{OP_RIGHT,   3,  2'd1, 8'd5,   8'h08};
        vecs[5]  = '{OP_PRESS,   1,  2'd2, 8'd5,   8'h05};
        vecs[6]  = '{OP_RIGHT,   2,  2'd2, 8'd5,   8'h05};
        vecs[7]  = '{OP_PRESS,   1,  2'd0, 8'd5,   8'h05};
        vecs[8]  = '{OP_RIGHT,   1,  2'd0, 8'd13,  8'h0D};
        vecs[9]  = '{OP_GLITCH,  1,  2'd0, 8'd13,  8'h0D};
        vecs[10] = '{OP_PARTIAL, 1,  2'd0, 8'd13,  8'h0D};
        vecs[11] = '{OP_INVALID, 1,  2'd0, 8'd13,  8'h0D};
        vecs[12] = '{OP_RIGHT,   1,  2'd0, 8'd21,  8'h15};
        vecs[13] = '{OP_RIGHT,   28, 2'd0, 8'd245, 8'hF5};
        vecs[14] = '{OP_PRESS,   1,  2'd1, 8'd245, 8'h08};
        vecs[15] = '{OP_LEFT,    3,  2'd1, 8'd245, 8'h01};
        vecs[16] = '{OP_LEFT,    1,  2'd1, 8'd245, 8'h01};
        vecs[17] = '{OP_PRESS,   1,  2'd2, 8'd245, 8'hF5};
        vecs[18] = '{OP_PRESS,   1,  2'd0, 8'd245, 8'hF5};
        vecs[19] = '{OP_RIGHT,   5,  2'd0, 8'd250, 8'hFA};
        vecs[20] = '{OP_PRESS,   1,  2'd1, 8'd250, 8'h01};
        vecs[21] = '{OP_RIGHT,   3,  2'd1, 8'd250, 8'h08};
        vecs[22] = '{OP_RIGHT,   5,  2'd1, 8'd250, 8'h80};
        vecs[23] = '{OP_LEFT,    4,  2'd1, 8'd250, 8'h08};
        vecs[24] = '{OP_PRESS,   1,  2'd2, 8'd250, 8'hFA};
        vecs[25] = '{OP_PRESS,   1,  2'd0, 8'd250, 8'hFA};
        vecs[26] = '{OP_RIGHT,   1,  2'd0, 8'd255, 8'hFF};
        vecs[27] = '{OP_RESET11, 1,  2'd0, 8'd1,   8'h01};

        reset       = 1'b1;
        enc_phase_a = 1'b0;
        enc_phase_b = 1'b0;
        enc_switch  = 1'b0;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);

        for (int r = 0; r < NVEC; r++) begin
            case (vecs[r].op)
                OP_RESET: begin
                    reset = 1'b1;
                    wait_clks(1);
                    reset = 1'b0;
                    check_all_zero("reset");
                end
                OP_LEFT:  for (int k = 0; k < vecs[r].count; k++) detent(1'b1);
                OP_RIGHT: for (int k = 0; k < vecs[r].count; k++) detent(1'b0);
                OP_PRESS: press_switch();
                OP_GLITCH: begin
                    set_phase(1'b1, 1'b0, 2);
                    set_phase(1'b0, 1'b0, 10);
                end
                OP_PARTIAL: begin
                    set_phase(1'b1, 1'b0, HOLD);
                    set_phase(1'b1, 1'b1, HOLD);
                    set_phase(1'b1, 1'b0, HOLD);
                    set_phase(1'b0, 1'b0, HOLD);
                end
                OP_INVALID: begin
                    set_phase(1'b1, 1'b1, 10);
                    set_phase(1'b0, 1'b0, 10);
                end
                default: begin
                    set_phase(1'b1, 1'b1, HOLD);
                    reset = 1'b1;
                    wait_clks(1);
                    reset = 1'b0;
                    check_all_zero("reset11");
                    set_phase(1'b1, 1'b1, 12);
                    set_phase(1'b0, 1'b0, 12);
                    detent(1'b0);
                end
            endcase

            wait_clks(20);
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL row%0d.pulses: got %0d missing step_pulses, required 0", r, exp_q.size());
                exp_q.delete();
            end
            chk($sformatf("row%0d.mode", r), {6'd0, mode}, {6'd0, vecs[r].exp_mode});
            chk($sformatf("row%0d.value", r), value, vecs[r].exp_value);
            chk($sformatf("row%0d.led", r), led, vecs[r].exp_led);
            $display("row %0d op=%s count=%0d mode=%0d value=%0d led=%02h",
                     r, vecs[r].op.name(), vecs[r].count, mode, value, led);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_input_controller.md
Name: encoder_input_controller

Overview:
- Front-end controller between the rotary encoder pins (enc_phase_a, enc_phase_b, enc_switch) and the Motherboard LED/value datapath.
- Does four jobs:
  - synchronises and debounces the encoder inputs at a divided sample rate;
  - decodes full quadrature detents with a state machine;
  - sequences a 3-mode edit FSM driven by the push switch;
  - applies steps to a saturating 8-bit value register and step-size register, which drive led.

Parameters:
- CLOCK_DIVIDER, default 100000: sample tick every CLOCK_DIVIDER clocks; 1 = every clock.
- DEBOUNCE_SAMPLES, default 4: consecutive ticks a changed input must hold before it is accepted; minimum 1.

Ports:
- clk100Mhz  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enc_phase_a  in  1  encoder phase A, asynchronous.
- enc_phase_b  in  1  encoder phase B, asynchronous.
- enc_switch  in  1  encoder push switch, active-high, asynchronous.
- step_pulse  out  1  one-clock pulse per completed detent.
- step_dir  out  1  direction of the step: 0 = right/CW, 1 = left/CCW; valid with step_pulse.
- mode  out  2  current mode: 0 EDIT_VALUE, 1 EDIT_STEP, 2 LOCKED.
- value  out  8  current edited value.
- led  out  8  display word.

Behaviour:
- Clock and reset: one clock (clk100Mhz); reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - step_pulse=0, step_dir=0, mode=0, value=0, led=0.
  - Internal step_size=1, divider count=0.
  - Synchroniser flops=0, debounced a/b/sw=0, debounce counters=0, quadrature FSM=IDLE.
  - Reset mid-rotation abandons the detent with no pulse.
- Synchroniser: 2-flop chain per input, clocked every cycle.
- Divider: counter 0..CLOCK_DIVIDER-1; tick asserts for one clock when count==CLOCK_DIVIDER-1, then count wraps to 0.
- Debounce (per input), evaluated on tick only:
  - If synced == debounced, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_SAMPLES-1 while the input still differs, debounced takes the synced value and the counter clears.
- Quadrature FSM: input is debounced {a,b}; it advances one transition per clock and only on a debounced change.
  - IDLE (00): 10->R1; 01->L1; 11->RESYNC.
  - R1 (10): 11->R2; 00->IDLE, no pulse; 01->RESYNC.
  - R2 (11): 01->R3; 10->R1; 00->RESYNC.
  - R3 (01): 00->IDLE with step_pulse=1, step_dir=0; 11->R2; 10->RESYNC.
  - L1 (01): 11->L2; 00->IDLE; 10->RESYNC.
  - L2 (11): 10->L3; 01->L1; 00->RESYNC.
  - L3 (10): 00->IDLE with step_pulse=1, step_dir=1; 11->L2; 01->RESYNC.
  - RESYNC: waits for 00, then ->IDLE with no pulse.
  - step_pulse is registered: it asserts the clock after the debounced 00 is registered.
- Switch: a press is the debounced sw 0->1 edge.
  - Each press advances mode EDIT_VALUE->EDIT_STEP->LOCKED->EDIT_VALUE.
  - Releases are ignored.
- Step application: on the clock after step_pulse, using the mode that was current at step_pulse.
  - EDIT_VALUE: right adds step_size, saturating at 255; left subtracts step_size, saturating at 0. Use 9-bit intermediate arithmetic.
  - EDIT_STEP: right doubles step_size, max 128; left halves it, min 1. step_size is always a power of two.
  - LOCKED: steps are ignored.
- Simultaneous press and step application in the same clock: the step uses the old mode, and the mode advances on the same edge.
- led, registered: EDIT_VALUE -> value; EDIT_STEP -> step_size; LOCKED -> value. led updates one clock after value, step_size or mode changes.
- Latency, raw pin edge to step_pulse:
  - 2 clocks of synchroniser;
  - up to DEBOUNCE_SAMPLES ticks of debounce;
  - 1 clock to register the debounced value;
  - 1 clock to step_pulse.
- Latency, step_pulse to led: value updates +1 clock, led +1 more.

Test Plan (CLOCK_DIVIDER=1, DEBOUNCE_SAMPLES=4, each phase held ≥8 clocks):
- Pulse reset high for one clock, then 3 left detents (00->01->11->10->00) -> 3 step_pulses, step_dir=1 each; value stays 0 (saturated); led=8'h00.
- 5 right detents (00->10->11->01->00) -> 5 step_pulses, step_dir=0; value=5; led=8'h05.
- Press/release switch, then 3 right detents -> mode=1, led=8'h08 (step_size 8).
  - Press again -> mode=2, led=8'h05; 2 right detents give step_pulses but value stays 5.
  - Press again -> mode=0; 1 right detent -> value=13, led=8'h0D.
- Glitch: A high for 2 clocks, then low -> debounced A never changes, no step_pulse; FSM stays IDLE.
- Partial and invalid sequences:
  - 00->10->11->10->00 -> no pulse.
  - 00->11 -> FSM in RESYNC, no pulse; back to 00 then one full right detent -> exactly one pulse, value +step_size.
- Saturation and reset:
  - With value 250, step_size 8, 1 right detent -> value=255.
  - Assert reset while phases are held at 11 -> all outputs 0 next clock, FSM in RESYNC after debounce; release to 00, then 1 right detent -> value=1.
